// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: the driver side owns the
// controls, the counter owns the registered count and flags.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;
    logic             load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  count, tc, wrap, done, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, tc, wrap, done, load_err
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-(MAX+1) up/down counter with load, clear, wrap or
// saturate end mode and a combinational terminal count for cascading.
module mod_updown_counter #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX      = (1 << WIDTH) - 1,
    parameter int          SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    mod_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        err_d   = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            done_d = 1'b0;
            if (bus.load_val > MAX_V) begin
                count_d = MAX_V;
                err_d   = 1'b1;
            end else begin
                count_d = bus.load_val;
            end
        end else if (bus.en && !done_q) begin
            // done_q can only be set in saturate mode, so this gate is a no-op when wrapping
            if (bus.up) begin
                if (!at_max)   count_d = count_q + WIDTH'(1);
                else if (SAT)  done_d  = 1'b1;
                else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero)  count_d = count_q - WIDTH'(1);
                else if (SAT)  done_d  = 1'b1;
                else begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // tc stays combinational so a cascaded stage sees it on the same edge
    assign bus.tc       = bus.en & ((bus.up & at_max) | (~bus.up & at_zero)) & ~(SAT & done_q);
    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.done     = SAT & done_q;
    assign bus.load_err = err_q;
endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous modulo-N up/down counter. It is the successor to the team's fixed 4-bit ripple counter. All state changes on the clock edge, so there is no ripple delay between bits. It adds width and modulus parameters, direction control, synchronous load and clear, a wrap or saturate end mode, and a terminal-count output for cascading. It is the general-purpose event and divide counter for the counter library, and it drives timers and baud or tick dividers.

## Interface
Parameters:
- WIDTH, default 8: count register width in bits; legal range 2..32.
- MAX, default 2**WIDTH-1: terminal value. The count range is 0..MAX. Legal range is 1..2**WIDTH-1.
- SATURATE, default 0: end mode. 0 wraps at the end of range. 1 stops at the end of range and raises done.

Ports (clock and reset first):
- clk  input  1  clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to clk.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value captured on load.
- en  input  1  count enable; also serves as the cascade carry-in.
- up  input  1  direction; 1 counts up, 0 counts down.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse on wrap.
- done  output  1  sticky end flag (SATURATE=1 only).
- load_err  output  1  registered one-cycle pulse on an out-of-range load.

## Operation
- Priority per cycle: clr, then load, then en. With none of them active, count holds.
- clr: count=0. wrap=0, done=0, load_err=0.
- load:
  - If load_val<=MAX: count=load_val, load_err=0.
  - Else: count=MAX, load_err=1.
  - In both cases done=0 and wrap=0.
- en with up=1:
  - If count<MAX: count+1.
  - If count==MAX and SATURATE=0: count=0, wrap=1.
  - If count==MAX and SATURATE=1: count holds at MAX, done=1.
- en with up=0:
  - If count>0: count-1.
  - If count==0 and SATURATE=0: count=MAX, wrap=1.
  - If count==0 and SATURATE=1: count holds at 0, done=1.
- Once done=1 with SATURATE=1, further en has no effect. The counter resumes only after clr or load.
- When SATURATE=0, done is tied to 0.
- Terminal count: tc = en & ((up & count==MAX) | (~up & count==0)).
  - With SATURATE=1, tc is additionally gated by ~done.
  - Cascading: a higher stage's en = lower stage's tc & global enable. The chain stays fully synchronous; no derived clocks.
- Arithmetic: count is compared and incremented in WIDTH bits. MAX is never exceeded, including when MAX < 2**WIDTH-1.
- Direction changes take effect on the same edge, with no extra latency.
- Non-power-of-two MAX is fully supported, e.g. WIDTH=4, MAX=9 gives a BCD digit.

## Timing
- Reset values:
  - count=0, wrap=0, done=0, load_err=0.
  - tc follows its equation, so it equals en & ~up while reset_n=0.
- Latency:
  - count reflects clr, load or en one cycle after the sampling edge.
  - wrap, done and load_err assert in the same cycle that count takes its new value.
  - wrap and load_err deassert on the next edge unless the condition repeats.
- tc is combinational from count, en and up, with no register stage. It is valid in the same cycle it is sampled by a downstream stage.
- Simultaneous events:
  - clr with load, en or a wrap condition: the clear wins, with no wrap and no load_err.
  - load with en: the load wins, and the count does not advance.
- Reset mid-operation: all outputs return to reset values asynchronously, regardless of clk. The first count after reset_n release happens on the first posedge where en=1.
- Continuous en over a full up-count wrap cycle: period MAX+1, exactly one wrap pulse per period.

## Test plan
- Reset and hold: WIDTH=4, MAX=9, pulse reset_n low mid-count at count=6 -> count=0 immediately; no wrap, done or load_err.
- Up wrap: MAX=9, en=1, up=1 from 0 for 12 clocks -> count 0..9,0,1,2; wrap high only in the cycle count returns to 0; tc high only while count==9.
- Down wrap and direction change: load 2, up=0, en=1 -> 1,0,9,8; set up=1 at count=8 -> 9,0 with wrap=1 on the 9->0 step.
- Saturate: SATURATE=1, MAX=5, up=1 from 3 for 5 clocks -> 4,5,5,5,5; done=1 from the first hold cycle; tc=0 once done=1; clr -> count=0, done=0.
- Load priority and range: load_val=12 with MAX=9 and en=1 -> count=9, load_err=1 for one cycle; clr with load=1 and load_val=3 -> count=0, load_err=0.
- Cascade: two instances with MAX=9, high.en = low.tc, en=1 for 100 clocks from 0 -> {high,low} returns to 0,0 with a single high-stage wrap pulse at clock 100; 99 is reached at clock 99.
